// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: valid/ready data-port responder with fixed wait states
// in front of a byte-enabled, word-addressed SRAM.
module riscv_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam bit NO_WAIT = WAIT_CYCLES == 0;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0] be_q;
    logic acc_we, acc_err, do_access;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0] acc_be;
    logic [ADDR_W-1:0] idx;
    logic [31:0] mem [2**ADDR_W];
    // Without wait states the access happens on the acceptance edge, straight from the request inputs
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        do_access = 1'b0;
        acc_we    = NO_WAIT ? req_we : we_q;
        acc_addr  = NO_WAIT ? req_addr : addr_q;
        acc_wdata = NO_WAIT ? req_wdata : wdata_q;
        acc_be    = NO_WAIT ? req_be : be_q;
        acc_err   = (|acc_addr[1:0]) || (|acc_addr[31:ADDR_W+2]);
        idx       = acc_addr[ADDR_W+1:2];
        case (state)
            IDLE: begin
                req_ready = !x_reset;
                if (req_valid) begin
                    state_nx  = NO_WAIT ? RESP : WAIT;
                    do_access = NO_WAIT && !x_reset;
                end
            end
            WAIT: begin
                do_access = (cnt == 4'd1) && !x_reset;
                state_nx  = (cnt == 4'd1) ? RESP : WAIT;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = rsp_ready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_we) ? '0 : mem[idx];
            end
        end
    end
    // Memory contents survive reset; only the access edge can write
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err)
            for (int i = 0; i < 4; i++)
                if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
endmodule

// File: doc/riscv_mem_responder.md
# riscv_mem_responder

Memory-side responder for the core's data port. It accepts one load/store request at a time over a valid/ready handshake and inserts a fixed number of wait states. It then performs a byte-enabled access to an internal word-addressed SRAM and returns the result over a valid/ready response channel. It replaces the zero-latency data RAM when the core moves to a stallable load/store unit.

## Interface
Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words
- WAIT_CYCLES, 2, wait states between request acceptance and the memory access (range 0..15)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- x_reset  input  1  reset, asynchronous and active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  byte enables; bit i enables byte lane wdata[8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  request was misaligned or out of range

## Operation
- FSM states are IDLE, WAIT and RESP. Reset enters IDLE.
- **IDLE**
  - req_ready=1.
  - If req_valid is high at an edge, the request is accepted: we, addr, wdata and be are latched, and the wait counter is loaded with WAIT_CYCLES.
  - Next state is WAIT, or RESP directly if WAIT_CYCLES=0.
- **WAIT**
  - req_ready=0.
  - The counter decrements on each edge.
  - The edge on which the counter reaches 0 performs the access and moves the FSM to RESP.
- **Access**, performed on a single edge:
  - err = (addr[1:0]!=0) OR (addr[31:ADDR_W+2]!=0).
  - Error: no write, rsp_rdata=0, rsp_err=1.
  - Store: each byte lane with be[i]=1 is written; other lanes are unchanged. rsp_rdata=0.
  - Load: rsp_rdata=mem[addr[ADDR_W+1:2]], registered. req_be is ignored for loads.
  - With WAIT_CYCLES=0, the access occurs on the acceptance edge.
- **RESP**
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until the handshake.
  - On an edge with rsp_ready=1, the FSM returns to IDLE.
  - No request is accepted on that same edge.
- A store with be=0 is a legal no-op: err=0, memory unchanged.
- Inputs on the request channel are ignored outside IDLE.
- Memory contents are not initialised or cleared by reset. The test bench preloads them via $readmemh.

## Timing
- Reset values: req_ready=0 while x_reset is high, then 1 from the first cycle after deassertion (IDLE). rsp_valid=0, rsp_rdata=0, rsp_err=0.
- For a request accepted at edge E0:
  - The access and rsp_valid rise occur at edge E0+WAIT_CYCLES.
  - Response accepted at edge E1 (E1 ≥ E0+WAIT_CYCLES): rsp_valid falls and req_ready rises at E1.
  - The next request can be accepted at E1+1 at the earliest.
- Minimum issue interval is WAIT_CYCLES+2 cycles.
- Reset asserted mid-transaction:
  - The FSM goes immediately to IDLE and all outputs take their reset values asynchronously.
  - A store whose access edge has not yet occurred is dropped.
  - A completed store remains in memory.
- Only one transaction is ever outstanding, so read-after-write ordering is inherent.

## Test plan
- **Reset/idle:** assert x_reset mid-cycle -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 immediately. After release, req_ready=1 on the next cycle.
- **Store then load, WAIT_CYCLES=2:**
  - Store addr 0x10, wdata 0xDEADBEEF, be=4'hF accepted at E0 -> rsp_valid at E0+2, rsp_rdata=0, err=0.
  - Load from 0x10 -> rsp_rdata=0xDEADBEEF.
- **Partial write:**
  - Preload word 4 = 0x11223344.
  - Store addr 0x10, wdata 0xAABBCCDD, be=4'b0101 -> subsequent load returns 0x11BB33DD.
  - Store with be=0 -> word unchanged, err=0.
- **Errors:**
  - Load at 0x13 -> err=1, rdata=0.
  - Store at 0x1000 (ADDR_W=10) -> err=1, and a load at 0x0 is unchanged.
- **Backpressure:** hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stay stable, and req_ready=0 throughout even with req_valid=1. Raising rsp_ready gives exactly one handshake, and the held request is accepted on the next cycle.
- **WAIT_CYCLES=0 and reset mid-WAIT:**
  - WAIT_CYCLES=0: rsp_valid is high the cycle after acceptance.
  - WAIT_CYCLES=3: assert reset one cycle after accepting a store to 0x20 -> the subsequent load from 0x20 returns the preloaded value.
